// File: rtl/cmd_stream_arbiter.sv
// Frame-granular arbiter feeding one controller command byte stream from two sources.
// Optional stall watchdog is compiled in with `define CMD_ARB_WATCHDOG_EN.
module cmd_stream_arbiter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] src0_byte,
  input  logic       src0_valid,
  input  logic       src0_last,
  output logic       src0_next,
  input  logic [7:0] src1_byte,
  input  logic       src1_valid,
  input  logic       src1_last,
  output logic       src1_next,
  output logic [7:0] out_byte,
  output logic       out_ready,
  input  logic       ctrl_next,
  output logic       ctrl_reset,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic       hold_last;
  logic       rr_ptr;

  logic       pick;
  logic [7:0] pick_byte;
  logic       pick_last;
  logic       owner;
  logic       own_valid;
  logic [7:0] own_byte;
  logic       own_last;

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

`ifdef CMD_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_count;
`endif

  // Arbitration choice in IDLE, and the granted source's signals in GRANT.
  always_comb begin
    pick      = (src0_valid && src1_valid) ? rr_ptr : ~src0_valid;
    pick_byte = pick ? src1_byte : src0_byte;
    pick_last = pick ? src1_last : src0_last;
    owner     = grant[1];
    own_valid = owner ? src1_valid : src0_valid;
    own_byte  = owner ? src1_byte  : src0_byte;
    own_last  = owner ? src1_last  : src0_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_last  <= 1'b0;
      rr_ptr     <= 1'b0;
      grant      <= 2'b00;
      out_byte   <= 8'h00;
      out_ready  <= 1'b0;
      src0_next  <= 1'b0;
      src1_next  <= 1'b0;
      timeout    <= 1'b0;
      ctrl_reset <= 1'b0;
`ifdef CMD_ARB_WATCHDOG_EN
      wd_count   <= '0;
`endif
    end else begin
      src0_next  <= 1'b0;
      src1_next  <= 1'b0;
      timeout    <= 1'b0;
      ctrl_reset <= 1'b0;
`ifdef CMD_ARB_WATCHDOG_EN
      wd_count   <= '0;
`endif
      case (state)
        IDLE: begin
          if (src0_valid || src1_valid) begin
            state     <= GRANT;
            grant     <= pick ? 2'b10 : 2'b01;
            out_byte  <= pick_byte;
            hold_last <= pick_last;
            out_ready <= 1'b1;
            if (pick) src1_next <= 1'b1;
            else      src0_next <= 1'b1;
          end
        end
        GRANT: begin
          if (out_ready) begin
            // Sources are not sampled while the hold is full, so a load never races ctrl_next.
            if (ctrl_next) begin
              out_ready <= 1'b0;
              if (hold_last) begin
                state  <= IDLE;
                grant  <= 2'b00;
                rr_ptr <= ~owner;
              end
            end
          end else if (own_valid) begin
            out_byte  <= own_byte;
            hold_last <= own_last;
            out_ready <= 1'b1;
            if (owner) src1_next <= 1'b1;
            else       src0_next <= 1'b1;
          end else begin
`ifdef CMD_ARB_WATCHDOG_EN
            if (wd_count == CW'(TIMEOUT_CYCLES - 1)) begin
              state      <= IDLE;
              grant      <= 2'b00;
              rr_ptr     <= ~rr_ptr;
              timeout    <= 1'b1;
              ctrl_reset <= 1'b1;
            end else begin
              wd_count <= wd_count + CW'(1);
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmd_stream_arbiter.md
# cmd_stream_arbiter

Shares the controller's single command-byte input between two byte-stream sources, for example the host link and an on-chip preset loader. Each grant covers one whole command frame, so frames from the two sources never interleave. A one-byte holding register sits between the granted source and the controller, and the block drives the controller's `in_byte`/`in_ready` pair and consumes its `next` pulse. A compile-time watchdog can abort a frame whose source stalls, and can reset the controller when it does.

## Interface
- `TIMEOUT_CYCLES`, default 65535: number of consecutive starved cycles inside a frame before the frame is aborted. Used only with the watchdog macro; must be at least 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `src0_byte`  in  8  source 0 data byte.
- `src0_valid`  in  1  source 0 has a byte on `src0_byte`.
- `src0_last`  in  1  the current source 0 byte ends its frame; sampled only with `src0_valid`.
- `src0_next`  out  1  one-cycle pulse: source 0 byte taken, source advances.
- `src1_byte`, `src1_valid`, `src1_last`, `src1_next`: same as source 0, for source 1.
- `out_byte`  out  8  to the controller's `in_byte`.
- `out_ready`  out  1  to the controller's `in_ready`; high while the holding register is full.
- `ctrl_next`  in  1  from the controller's `next`; the held byte has been consumed.
- `ctrl_reset`  out  1  one-cycle pulse to the controller's `reset` on watchdog abort.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `timeout`  out  1  one-cycle abort flag.

## Operation
- Reset values: state IDLE, hold empty, `grant`=00, `out_byte`=0, `rr_ptr`=0 (source 0 preferred), watchdog count 0. All outputs are 0.
- All outputs are registered.
- **IDLE state**
  - If exactly one source is valid at a clock edge, grant it.
  - If both are valid, grant the source indicated by `rr_ptr`.
  - In the same edge: load `hold` with the byte, latch its `last` bit, pulse the granted `srcN_next`, go to GRANT.
- **GRANT state**
  - Hold empty and the granted source valid: load `hold`, latch `last`, pulse `srcN_next`.
  - Hold full: sources are not sampled, and the non-granted source is ignored for the whole frame.
  - `ctrl_next` while hold full: hold empties at that edge.
  - If the latched `last`=1 when it empties, the frame is over: go to IDLE, `grant`=00, `rr_ptr` set to the other source.
- `ctrl_next` while hold empty is ignored. No error is raised.
- `srcN_next` is never asserted for a source that is not granted.
- `ctrl_reset` is 0 in normal operation. It is driven only by the watchdog.

## Timing
- First byte latency:
  - Source valid at edge t in IDLE, then `out_ready`=1 and `srcN_next` pulse in cycle t+1.
  - Source must present its next byte, or drop valid, by edge t+2.
- Steady state:
  - `ctrl_next` at edge u empties the hold.
  - The next byte is loaded at edge u+1, and `out_ready` is high again in cycle u+2.
  - This gives the controller its required one idle cycle after each `next`.
- Frame switch: last byte consumed at edge u gives IDLE in cycle u+1. The other source can be granted at edge u+1, with `out_ready` high in cycle u+2.
- Simultaneous events:
  - Reset wins over everything.
  - Because `ctrl_next` and a load never coincide (a load requires the hold empty), no byte can be overwritten.
- Reset mid-frame: the hold is discarded and the source is not notified. The source must restart its frame after reset.

## Configuration
- Macro `CMD_ARB_WATCHDOG_EN`:
  - **Defined:** a counter runs while in GRANT with the hold empty and the granted source not valid. It clears on any load or on leaving GRANT.
    - On reaching `TIMEOUT_CYCLES`: pulse `timeout` and `ctrl_reset` for one cycle, go to IDLE, `grant`=00, toggle `rr_ptr`, clear the counter.
  - **Not defined:** there is no counter, `timeout` and `ctrl_reset` are held at 0, and a stalled frame holds the grant indefinitely.

## Test plan
- **Single source, 3-byte frame:** src0 sends 0x01, 0x05, 0x7F (last) with the controller model pulsing `ctrl_next` 2 cycles after `out_ready`. Required: `out_byte` sequence 01,05,7F, `grant`=01 throughout, 3 `src0_next` pulses, then `grant`=00.
- **Both sources valid from reset:** src0 frame {0x02, 0xAA(last)}, src1 frame {0x06(last)}. Required: src0 served first, src1 granted 1 cycle after 0xAA is consumed, no interleaving, `rr_ptr` then favours src0.
- **Contention during a frame:** src1 asserts valid mid-src0 frame. Required: no `src1_next` until src0's last byte is consumed.
- **Back-to-back same source:** src0 sends two frames while src1 stays idle. Required: second frame granted to src0 at the first IDLE edge.
- **Watchdog (macro on, `TIMEOUT_CYCLES`=8):** src0 sends 0x01, then drops valid. Required: `timeout` and `ctrl_reset` pulse exactly 8 cycles after the hold empties, then `grant`=00. With the macro off: no pulse after 1000 cycles.
- **Async reset mid-frame, hold full:** assert `reset` asynchronously. Required: `out_ready`, `grant`, and both `srcN_next` go to 0 immediately, and src0 is preferred after release.
